// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: synchronise/debounce set, clear, toggle requests into spaced single-cycle J/K pulses.
// Define JK_CMD_STATS_EN to build the cmd_count command counter (otherwise it reads 0).
module jk_cmd_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       clr_in,
  input  logic       tog_in,
  output logic       J,
  output logic       K,
  output logic       busy,
  output logic [7:0] cmd_count
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state, state_d;
  logic [2:0] s1, s2, stable, rise, pend, pend_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic j_d, k_d, take;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2, s1} <= '0;
    else {s2, s1} <= {s1, tog_in, clr_in, set_in};
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CNT_W-1:0] c;
    logic st;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        c  <= '0;
        st <= 1'b0;
      end else if (s2[i] == st) c <= '0;
      else if (c == DB_LAST) begin
        c  <= '0;
        st <= s2[i];
      end else c <= c + 1'b1;
    assign stable[i] = st;
    assign rise[i] = s2[i] & ~st & (c == DB_LAST);
  end
  // flags consumed by a pulse are cleared, but a rise on the same edge re-arms its flag
  always_comb begin
    take    = (state == IDLE) && |pend;
    j_d     = take & (pend[0] | pend[2]);
    k_d     = take & (pend[1] | pend[2]);
    pend_d  = (take ? 3'b000 : pend) | rise;
    gcnt_d  = state == GAP ? gcnt + 1'b1 : '0;
    state_d = take ? PULSE :
              ((state == PULSE && GAP_CYCLES > 0) || (state == GAP && gcnt != GAP_LAST)) ? GAP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
      pend  <= '0;
      J     <= 1'b0;
      K     <= 1'b0;
    end else begin
      state <= state_d;
      gcnt  <= gcnt_d;
      pend  <= pend_d;
      J     <= j_d;
      K     <= k_d;
    end
  assign busy = state != IDLE;
`ifdef JK_CMD_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) cmd_count <= '0;
    else if (take) cmd_count <= cmd_count + 8'd1;
`else
  assign cmd_count = 8'd0;
`endif
endmodule

// File: tb/tb_jk_cmd_gen.sv
// tb_jk_cmd_gen: directed + random request stimulus against a window/event reference model,
// expected pulses queued by the model and popped by an independent output monitor.
module tb_jk_cmd_gen;
  localparam int DB = 4;
  localparam int GAP = 2;
  logic clk = 1'b0, rst = 1'b1, set_in = 1'b0, clr_in = 1'b0, tog_in = 1'b0;
  logic J, K, busy;
  logic [7:0] cmd_count;
  int total = 0, bad = 0;

  jk_cmd_gen #(.DB_CYCLES(DB), .CNT_W(8), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .tog_in(tog_in),
    .J(J), .K(K), .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [1:0] jk; int e;} exp_t;
  exp_t q[$];
  exp_t x;
  logic [2:0] hist[$];
  logic [2:0] win[$];
  logic [2:0] stab = '0, pend = '0, s2m, rise;
  bit issued = 0, exp_busy = 0, flip;
  int ecount = 0, last_issue = 0, exp_count = 0;
  int pulses = 0, last_pulse_e = -1000, prev_pulse_e = -1000;
  int t0, p0, pe;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  // Reference model: s2 is the raw sample from two edges back; a stable value flips once the
  // last DB synchronised samples all disagree with it. Commands issue when idle and cooled down.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      hist.delete();
      hist.push_back(3'b000);
      hist.push_back(3'b000);
      win.delete();
      stab = '0;
      pend = '0;
      issued = 0;
      exp_busy = 0;
      exp_count = 0;
    end else begin
      ecount++;
      s2m = hist[0];
      hist.push_back({tog_in, clr_in, set_in});
      void'(hist.pop_front());
      win.push_back(s2m);
      if (win.size() > DB) void'(win.pop_front());
      rise = '0;
      for (int i = 0; i < 3; i++) begin
        flip = win.size() == DB;
        foreach (win[k]) if (win[k][i] == stab[i]) flip = 0;
        if (flip) begin
          stab[i] = ~stab[i];
          rise[i] = stab[i];
        end
      end
      if (pend != 0 && (!issued || ecount >= last_issue + GAP + 2)) begin
        q.push_back('{jk: {pend[0] | pend[2], pend[1] | pend[2]}, e: ecount});
        issued = 1;
        last_issue = ecount;
        pend = '0;
`ifdef JK_CMD_STATS_EN
        exp_count = (exp_count + 1) % 256;
`endif
      end
      pend |= rise;
      exp_busy = issued && (ecount - last_issue) <= GAP;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, exp_busy);
      chk("cmd_count", cmd_count, exp_count);
      if (J || K) begin
        pulses++;
        prev_pulse_e = last_pulse_e;
        last_pulse_e = ecount;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse got JK=%b at edge %0d, required none", {J, K}, ecount);
        end else begin
          x = q.pop_front();
          chk("pulse_jk", {J, K}, x.jk);
          chk("pulse_edge", ecount, x.e);
        end
      end else if (q.size() != 0 && q[0].e <= ecount) begin
        total++;
        bad++;
        $display("FAIL missing_pulse got none, required JK=%b at edge %0d", q[0].jk, q[0].e);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(logic [2:0] held);
    @(negedge clk);
    {tog_in, clr_in, set_in} = held;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_pulse(string n, int start);
    int p = pulses;
    for (int i = 0; i < 30 && pulses == p; i++) begin
      @(negedge clk);
      #1;
    end
    chk(n, last_pulse_e - start, DB + 2);
  endtask

  initial begin
    #1;
    chk("rst_J", J, 0);
    chk("rst_K", K, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cmd_count, 0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    set_in = 1'b1;
    t0 = ecount + 1;
    wait_pulse("set_latency", t0);
    cyc(10);
    set_in = 1'b0;
    cyc(8);
    set_in = 1'b1;
    for (int i = 0; i < 30 && !J; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_J", J, 1);
    #1 rst = 1'b1;
    #1;
    chk("midpulse_rst_J", J, 0);
    chk("midpulse_rst_K", K, 0);
    chk("midpulse_rst_busy", busy, 0);
    chk("midpulse_rst_count", cmd_count, 0);
    @(negedge clk);
    set_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    p0 = pulses;
    cyc(20);
    chk("no_pulse_after_rst", pulses - p0, 0);
    do_reset(3'b001);
    p0 = pulses;
    cyc(15);
    chk("held_through_rst", pulses - p0, 1);
    set_in = 1'b0;
    cyc(8);
    repeat (10) begin
      clr_in = ~clr_in;
      cyc(2);
    end
    p0 = pulses;
    clr_in = 1'b1;
    t0 = ecount + 1;
    wait_pulse("bounce_latency", t0);
    cyc(10);
    chk("bounce_pulses", pulses - p0, 1);
    clr_in = 1'b0;
    cyc(8);
    p0 = pulses;
    set_in = 1'b1;
    clr_in = 1'b1;
    cyc(15);
    chk("simul_pulses", pulses - p0, 1);
    set_in = 1'b0;
    clr_in = 1'b0;
    do_reset(3'b000);
    cyc(3);
    p0 = pulses;
    set_in = 1'b1;
    cyc(2);
    tog_in = 1'b1;
    cyc(20);
    chk("b2b_pulses", pulses - p0, 2);
    chk("b2b_spacing", last_pulse_e - prev_pulse_e, GAP + 2);
`ifdef JK_CMD_STATS_EN
    pe = 2;
`else
    pe = 0;
`endif
    chk("b2b_count", cmd_count, pe);
    set_in = 1'b0;
    tog_in = 1'b0;
    do_reset(3'b000);
    repeat (400) begin
      {tog_in, clr_in, set_in} = 3'($urandom);
      cyc($urandom_range(1, 10));
    end
    {tog_in, clr_in, set_in} = 3'b000;
    cyc(20);
    do_reset(3'b000);
    p0 = pulses;
    repeat (256) begin
      tog_in = 1'b1;
      cyc(7);
      tog_in = 1'b0;
      cyc(7);
    end
    cyc(10);
    chk("wrap_pulses", pulses - p0, 256);
    chk("wrap_count", cmd_count, 0);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
